// File: rtl/sprite_blitter.sv
// Purpose: draws queued sprites into the framebuffer on each frame_start; optional SPRITE_BLIT_HFLIP_EN adds horizontal mirroring.
// Latency: 2 cycles per skipped pixel, 3 per written pixel; frame_done pulses 3 cycles after frame_start on an empty queue.
// Backpressure: a write holds fb_we/fb_addr/fb_data until fb_ready is sampled high; the pixel walk stalls meanwhile.
module sprite_blitter #(
    parameter int         SPRITE_W    = 32,
    parameter int         SPRITE_H    = 32,
    parameter int         FB_W        = 640,
    parameter int         FB_H        = 480,
    parameter int         MAX_SPRITES = 16,
    parameter logic [7:0] TRANSPARENT = 8'h00
) (
    input  logic                                     i_clock,
    input  logic                                     i_reset,
    input  logic                                     i_frame_start,
    input  logic                                     i_is_empty,
    input  logic [7:0]                               i_sprite_id,
    input  logic [15:0]                              i_sprite_x,
    input  logic [15:0]                              i_sprite_y,
    input  logic [7:0]                               i_sprite_scale,
    output logic                                     o_dequeue,
    output logic [8+$clog2(SPRITE_W*SPRITE_H)-1:0]   o_rom_addr,
    input  logic [7:0]                               i_rom_data,
    output logic                                     o_fb_we,
    output logic [$clog2(FB_W*FB_H)-1:0]             o_fb_addr,
    output logic [7:0]                               o_fb_data,
    input  logic                                     i_fb_ready,
    output logic                                     o_busy,
    output logic                                     o_frame_done
);

    localparam int CW   = $clog2(SPRITE_W);
    localparam int RW   = $clog2(SPRITE_H);
    localparam int DXW  = CW + 3;
    localparam int DYW  = RW + 3;
    localparam int AW   = $clog2(FB_W * FB_H);
    localparam int CNTW = $clog2(MAX_SPRITES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_LOAD, S_FETCH, S_PIXEL, S_WRITE, S_POP, S_SETTLE, S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_id;
    logic [15:0]       r_x;
    logic [15:0]       r_y;
    logic [1:0]        r_s;
    logic [DXW-1:0]    r_dx;
    logic [DYW-1:0]    r_dy;
    logic [CNTW-1:0]   r_cnt;
    logic              r_fb_we;
    logic [AW-1:0]     r_fb_addr;
    logic [7:0]        r_fb_data;
    logic              r_frame_done;

    logic              w_load;
    logic              w_advance;
    logic              w_wr_start;
    logic [DXW-1:0]    w_dx_max;
    logic [DYW-1:0]    w_dy_max;
    logic              w_last_col;
    logic              w_last_pix;
    logic [CW-1:0]     w_col;
    logic [RW-1:0]     w_row;
    logic [CW-1:0]     w_src_col;
    logic [16:0]       w_px;
    logic [16:0]       w_py;
    logic              w_visible;
    logic [AW-1:0]     w_pix_addr;

`ifdef SPRITE_BLIT_HFLIP_EN
    logic              r_hflip;
    logic              w_unused_scale;
    assign w_unused_scale = ^i_sprite_scale[6:2];
    // Mirrored column: SPRITE_W-1-col is the bitwise complement for a power-of-two width.
    assign w_src_col = r_hflip ? ~w_col : w_col;
`else
    logic              w_unused_scale;
    assign w_unused_scale = ^i_sprite_scale[7:2];
    assign w_src_col = w_col;
`endif

    // Scaled rectangle bounds and source texel coordinates for the current dx/dy.
    assign w_dx_max   = DXW'((SPRITE_W << r_s) - 1);
    assign w_dy_max   = DYW'((SPRITE_H << r_s) - 1);
    assign w_last_col = (r_dx == w_dx_max);
    assign w_last_pix = w_last_col && (r_dy == w_dy_max);
    assign w_col      = CW'(r_dx >> r_s);
    assign w_row      = RW'(r_dy >> r_s);
    assign o_rom_addr = {r_id, w_row, w_src_col};

    // Destination coordinates are 17 bits so x+dx beyond 65535 is clipped rather than wrapped.
    assign w_px       = {1'b0, r_x} + 17'(r_dx);
    assign w_py       = {1'b0, r_y} + 17'(r_dy);
    assign w_visible  = (i_rom_data != TRANSPARENT) && (w_px < 17'(FB_W)) && (w_py < 17'(FB_H));
    assign w_pix_addr = AW'(w_py) * AW'(FB_W) + AW'(w_px);

    assign o_dequeue    = (r_state == S_POP);
    assign o_busy       = (r_state != S_IDLE);
    assign o_fb_we      = r_fb_we;
    assign o_fb_addr    = r_fb_addr;
    assign o_fb_data    = r_fb_data;
    assign o_frame_done = r_frame_done;

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state decode and datapath control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        w_wr_start  = 1'b0;
        case (r_state)
            S_IDLE:   if (i_frame_start) w_state_nxt = S_CHECK;
            S_CHECK:  w_state_nxt = (i_is_empty || (r_cnt == CNTW'(MAX_SPRITES))) ? S_DONE : S_LOAD;
            S_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_FETCH:  w_state_nxt = S_PIXEL;
            S_PIXEL: begin
                if (w_visible) begin
                    w_wr_start  = 1'b1;
                    w_state_nxt = S_WRITE;
                end else begin
                    w_advance   = 1'b1;
                    w_state_nxt = w_last_pix ? S_POP : S_FETCH;
                end
            end
            S_WRITE: begin
                if (i_fb_ready) begin
                    w_advance   = 1'b1;
                    w_state_nxt = w_last_pix ? S_POP : S_FETCH;
                end
            end
            S_POP:    w_state_nxt = S_SETTLE;
            S_SETTLE: w_state_nxt = S_CHECK;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Sprite fields, pixel walk, framebuffer write registers and per-frame sprite count.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_id         <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_s          <= '0;
            r_dx         <= '0;
            r_dy         <= '0;
            r_cnt        <= '0;
            r_fb_we      <= 1'b0;
            r_fb_addr    <= '0;
            r_fb_data    <= '0;
            r_frame_done <= 1'b0;
`ifdef SPRITE_BLIT_HFLIP_EN
            r_hflip      <= 1'b0;
`endif
        end else begin
            r_frame_done <= (r_state == S_DONE);
            if (w_load) begin
                r_id <= i_sprite_id;
                r_x  <= i_sprite_x;
                r_y  <= i_sprite_y;
                r_s  <= i_sprite_scale[1:0];
                r_dx <= '0;
                r_dy <= '0;
`ifdef SPRITE_BLIT_HFLIP_EN
                r_hflip <= i_sprite_scale[7];
`endif
            end
            if (w_advance) begin
                r_fb_we <= 1'b0;
                if (w_last_col) begin
                    r_dx <= '0;
                    r_dy <= r_dy + DYW'(1);
                end else begin
                    r_dx <= r_dx + DXW'(1);
                end
            end
            if (w_wr_start) begin
                r_fb_we   <= 1'b1;
                r_fb_addr <= w_pix_addr;
                r_fb_data <= i_rom_data;
            end
            if (r_state == S_POP)       r_cnt <= r_cnt + CNTW'(1);
            else if (r_state == S_DONE) r_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: queue and ROM models, scoreboard of expected framebuffer writes.
// Expected writes come from walking each sprite's scaled rectangle with plain integer arithmetic.
// One negedge process checks every accepted write, held writes and dequeue pulses.
module tb_sprite_blitter;

    logic        clock = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        is_empty;
    logic [7:0]  sprite_id;
    logic [15:0] sprite_x;
    logic [15:0] sprite_y;
    logic [7:0]  sprite_scale;
    logic        dequeue;
    logic [17:0] rom_addr;
    logic [7:0]  rom_data;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_ready;
    logic        busy;
    logic        frame_done;
    logic        rdy_rand;

    sprite_blitter dut (
        .i_clock(clock), .i_reset(reset), .i_frame_start(frame_start), .i_is_empty(is_empty),
        .i_sprite_id(sprite_id), .i_sprite_x(sprite_x), .i_sprite_y(sprite_y),
        .i_sprite_scale(sprite_scale), .o_dequeue(dequeue), .o_rom_addr(rom_addr),
        .i_rom_data(rom_data), .o_fb_we(fb_we), .o_fb_addr(fb_addr), .o_fb_data(fb_data),
        .i_fb_ready(fb_ready), .o_busy(busy), .o_frame_done(frame_done)
    );

    always #5 clock = ~clock;

    logic [7:0] rom_mem [0:262143];
    always @(posedge clock) rom_data <= rom_mem[rom_addr];

    typedef struct {int id; int x; int y; int sc;} spr_t;
    typedef struct {int addr; int data;} wr_t;
    spr_t sq[$];
    wr_t  expq[$];

    int checks = 0, failures = 0;
    int deq_cnt = 0, fd_cnt = 0, wr_cnt = 0, stall_cnt = 0, zero_cnt = 0;
    int first_addr = -1, last_addr = -1;
    int n_draw, d0, f0, exp_n;
    logic        hold_vld = 1'b0;
    logic        prev_deq = 1'b0;
    logic [18:0] h_addr;
    logic [7:0]  h_data;

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endfunction

    function automatic void refresh_head();
        is_empty = (sq.size() == 0);
        if (sq.size() != 0) begin
            sprite_id    = 8'(sq[0].id);
            sprite_x     = 16'(sq[0].x);
            sprite_y     = 16'(sq[0].y);
            sprite_scale = 8'(sq[0].sc);
        end
    endfunction

    // Reference: every destination pixel of the scaled rectangle, in raster order.
    function automatic void expect_sprite(input spr_t s);
        int sh, n, col, row, v, px, py;
        sh = s.sc & 3;
        n  = 32 << sh;
        for (int dy = 0; dy < n; dy++) begin
            for (int dx = 0; dx < n; dx++) begin
                col = dx >> sh;
                row = dy >> sh;
`ifdef SPRITE_BLIT_HFLIP_EN
                if ((s.sc & 128) != 0) col = 31 - col;
`endif
                v  = int'(rom_mem[s.id * 1024 + row * 32 + col]);
                px = s.x + dx;
                py = s.y + dy;
                if (v != 0 && px < 640 && py < 480) expq.push_back('{py * 640 + px, v});
            end
        end
    endfunction

    // Per-cycle compare: held writes, accepted writes, dequeue pulses and queue pop.
    always @(negedge clock) begin
        wr_t w;
        if (reset) begin
            hold_vld = 1'b0;
            prev_deq = 1'b0;
        end else begin
            if (hold_vld) begin
                chk("hold_we", int'(fb_we), 1);
                chk("hold_addr", int'(fb_addr), int'(h_addr));
                chk("hold_data", int'(fb_data), int'(h_data));
            end
            if (dequeue) begin
                chk("deq_width", int'(prev_deq), 0);
                deq_cnt++;
                if (sq.size() != 0) sq.delete(0);
                refresh_head();
            end
            if (fb_we && fb_ready) begin
                if (wr_cnt == 0) first_addr = int'(fb_addr);
                last_addr = int'(fb_addr);
                wr_cnt++;
                if (fb_data == 8'h00) zero_cnt++;
                if (expq.size() == 0) begin
                    chk("write_overrun", expq.size(), 1);
                end else begin
                    w = expq.pop_front();
                    chk("wr_addr", int'(fb_addr), w.addr);
                    chk("wr_data", int'(fb_data), w.data);
                end
            end
            hold_vld = fb_we && !fb_ready;
            if (hold_vld) stall_cnt++;
            h_addr = fb_addr;
            h_data = fb_data;
            if (frame_done) fd_cnt++;
            prev_deq = dequeue;
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rdy_rand) fb_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic push_sprite(input int id, input int x, input int y, input int sc);
        sq.push_back('{id, x, y, sc});
        refresh_head();
    endtask

    task automatic start_frame(input int lit);
        n_draw = (sq.size() < 16) ? sq.size() : 16;
        expq.delete();
        for (int i = 0; i < n_draw; i++) expect_sprite(sq[i]);
        exp_n = expq.size();
        if (lit >= 0) chk("model_writes", exp_n, lit);
        wr_cnt = 0; stall_cnt = 0; zero_cnt = 0; first_addr = -1; last_addr = -1;
        d0 = deq_cnt;
        f0 = fd_cnt;
        @(posedge clock); #1 frame_start = 1'b1;
        @(posedge clock); #1 frame_start = 1'b0;
    endtask

    task automatic finish_frame(input int budget);
        int c;
        c = 0;
        while (fd_cnt == f0 && c < budget) begin
            @(posedge clock);
            c++;
        end
        #1;
        chk("frame_done_seen", fd_cnt - f0, 1);
        chk("writes_total", wr_cnt, exp_n);
        chk("writes_missing", expq.size(), 0);
        chk("dequeues", deq_cnt - d0, n_draw);
        chk("zero_data", zero_cnt, 0);
        chk("busy_after", int'(busy), 0);
    endtask

    task automatic wait_we(input string name);
        int c;
        c = 0;
        while (!fb_we && c < 500) begin
            @(posedge clock); #1;
            c++;
        end
        chk(name, int'(fb_we), 1);
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; fb_ready = 1'b1; rdy_rand = 1'b0;
        sprite_id = '0; sprite_x = '0; sprite_y = '0; sprite_scale = '0;
        refresh_head();
        for (int a = 0; a < 262144; a++) rom_mem[a] = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_dequeue", int'(dequeue), 0);
        chk("rst_fb_we", int'(fb_we), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_fb_addr", int'(fb_addr), 0);
        chk("rst_fb_data", int'(fb_data), 0);
        @(posedge clock); #1 reset = 1'b0;

        // Unscaled sprite fully on screen.
        for (int i = 0; i < 1024; i++) rom_mem[1024 + i] = 8'h05;
        push_sprite(1, 200, 200, 0);
        start_frame(1024);
        finish_frame(6000);
        chk("t1_first_addr", first_addr, 128200);
        chk("t1_last_addr", last_addr, 148071);
        chk("t1_deq", deq_cnt - d0, 1);

        // 2x scale: each texel becomes a 2x2 block.
        for (int i = 0; i < 1024; i++) rom_mem[3072 + i] = 8'((i % 255) + 1);
        push_sprite(3, 300, 300, 1);
        start_frame(4096);
        finish_frame(20000);
        chk("t2_first_addr", first_addr, 192300);
        chk("t2_last_addr", last_addr, 232683);

        // Right-edge clipping.
        push_sprite(1, 620, 0, 0);
        start_frame(640);
        finish_frame(6000);
        chk("t3_first_addr", first_addr, 620);
        chk("t3_last_addr", last_addr, 20479);
        chk("t3_deq", deq_cnt - d0, 1);

        // Transparent columns plus a 5-cycle stall on the first write.
        for (int i = 0; i < 1024; i++) rom_mem[2048 + i] = (i % 2 == 1) ? 8'h07 : 8'h00;
        push_sprite(2, 10, 10, 0);
        fb_ready = 1'b0;
        start_frame(512);
        wait_we("t4_we_seen");
        repeat (5) @(posedge clock);
        #1 fb_ready = 1'b1;
        finish_frame(6000);
        chk("t4_stall_cycles", stall_cnt, 5);
        chk("t4_first_addr", first_addr, 6411);

        // Empty queue: frame_done exactly 3 cycles after frame_start.
        d0 = deq_cnt; wr_cnt = 0;
        @(posedge clock); #1 frame_start = 1'b1;
        @(posedge clock); #1 frame_start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            chk("empty_frame_done", int'(frame_done), (k == 3) ? 1 : 0);
        end
        @(negedge clock);
        chk("empty_fd_width", int'(frame_done), 0);
        chk("empty_deq", deq_cnt - d0, 0);
        chk("empty_writes", wr_cnt, 0);

        // 20 queued fully transparent sprites: only 16 are drawn and popped.
        for (int i = 0; i < 20; i++) push_sprite(20, int'($urandom_range(0, 700)), int'($urandom_range(0, 500)), 0);
        start_frame(0);
        finish_frame(40000);
        chk("t6_deq16", deq_cnt - d0, 16);
        chk("t6_left", sq.size(), 4);
        sq.delete();
        refresh_head();

        // Random textures, positions near the edges, random scale upper bits and random fb_ready.
        for (int i = 0; i < 2048; i++)
            rom_mem[8192 + i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        for (int i = 0; i < 2; i++)
            push_sprite(8 + i, int'($urandom_range(560, 700)), int'($urandom_range(420, 500)),
                        int'($urandom_range(0, 255) & 32'hFC));
        rdy_rand = 1'b1;
        start_frame(-1);
        finish_frame(20000);
        rdy_rand = 1'b0;
        @(posedge clock); #1 fb_ready = 1'b1;

        // Reset while a write is stalled.
        push_sprite(1, 0, 0, 0);
        fb_ready = 1'b0;
        start_frame(1024);
        wait_we("t8_we_seen");
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("t8_fb_we_after_rst", int'(fb_we), 0);
        chk("t8_busy_after_rst", int'(busy), 0);
        chk("t8_no_deq", deq_cnt - d0, 0);
        @(posedge clock); #1 reset = 1'b0;
        fb_ready = 1'b1;
        start_frame(1024);
        finish_frame(6000);
        chk("t8_first_addr", first_addr, 0);
        chk("t8_last_addr", last_addr, 19871);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Downstream consumer of the sprite queue: on each frame-start pulse, drains queued sprites one at a time.
- Per sprite: latches the head entry (id, x, y, scale), walks the scaled destination rectangle, fetches palette indices from sprite ROM and writes non-transparent, on-screen pixels to the framebuffer write port.
- Pops the queue with a one-cycle dequeue pulse after each sprite.

Parameters:
SPRITE_W, 32, source sprite width in pixels (power of two)
SPRITE_H, 32, source sprite height in pixels (power of two)
FB_W, 640, framebuffer width
FB_H, 480, framebuffer height
MAX_SPRITES, 16, maximum sprites drawn per frame
TRANSPARENT, 8'h00, palette index that is skipped

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_start  in  1  single-cycle pulse that begins a frame's draw pass
is_empty  in  1  queue empty flag
sprite_id  in  8  queue head id
sprite_x  in  16  queue head x, unsigned
sprite_y  in  16  queue head y, unsigned
sprite_scale  in  8  queue head scale; bits[1:0] = log2 factor
dequeue  out  1  one-cycle pop pulse to queue
rom_addr  out  8+clog2(SPRITE_W*SPRITE_H)  sprite ROM address
rom_data  in  8  ROM read data, valid 1 cycle after rom_addr
fb_we  out  1  framebuffer write request
fb_addr  out  clog2(FB_W*FB_H)  y*FB_W + x
fb_data  out  8  palette index
fb_ready  in  1  framebuffer accepts write when fb_we && fb_ready
busy  out  1  high in any state but IDLE
frame_done  out  1  one-cycle pulse at end of pass

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset: state IDLE.
- Outputs zero on reset: dequeue, fb_we, frame_done, busy, rom_addr, fb_addr, fb_data, sprite counter.
- Reset mid-operation: abandons the sprite immediately. fb_we is low on the cycle after reset is sampled. No dequeue is issued.
- States and transitions:
  - IDLE: on frame_start, go to CHECK. frame_start is ignored in all other states.
  - CHECK: if is_empty or sprite counter == MAX_SPRITES, go to DONE; else go to LOAD.
  - LOAD: register id/x/y/scale.
    - s = scale[1:0]; destination size = SPRITE_W<<s by SPRITE_H<<s.
    - Reset dx = dy = 0. Go to FETCH.
  - FETCH: rom_addr = id*SPRITE_W*SPRITE_H + (dy>>s)*SPRITE_W + (dx>>s). Go to PIXEL.
  - PIXEL: evaluate rom_data, px = x+dx, py = y+dy (17-bit compare, no wrap).
    - Pixel is skipped if rom_data == TRANSPARENT, px >= FB_W, or py >= FB_H; then advance.
    - Otherwise drive fb_we = 1, fb_addr = py*FB_W+px, fb_data = rom_data, and go to WRITE.
  - WRITE: hold fb_we/fb_addr/fb_data stable until fb_ready is sampled high, then deassert fb_we and advance.
  - Advance: dx++. At dx wrap (== width-1), dx = 0 and dy++. After the last pixel (dx, dy both at max), go to POP; else go to FETCH.
  - POP: dequeue = 1 for exactly one cycle; increment sprite counter. Go to SETTLE.
  - SETTLE: dequeue = 0, waiting one cycle for the queue's updated is_empty. Go to CHECK.
  - DONE: frame_done = 1 for one cycle; clear sprite counter. Go to IDLE.
- Timing: minimum 2 cycles per skipped pixel, 3 per written pixel (FETCH, PIXEL, WRITE with fb_ready already high).
- Scale bits[7:2] are ignored, except bit 7 under the optional feature.
- Fields are latched in LOAD; head changes after LOAD do not affect the sprite in flight.

Optional Feature:
- SPRITE_BLIT_HFLIP_EN:
  - Defined: sprite_scale[7] = 1 mirrors horizontally; the source column becomes SPRITE_W-1-(dx>>s).
  - Undefined: bit 7 is ignored, and the flip logic is absent.

Test Plan:
- id=1, (200,200), scale=0, ROM all 8'h05, fb_ready=1 -> 1024 writes; first fb_addr=128200, last=148071; one dequeue pulse; then frame_done.
- id=3, (300,300), scale=1 -> 4096 writes over x 300..363, y 300..363; each ROM texel written 4 times (2x2 block).
- x=620, y=0, scale=0 -> 640 writes, x 620..639 only; no write with px>=640; dequeue still pulses.
- ROM alternating 8'h00/8'h07 per column -> 512 writes, none with fb_data=0. fb_ready low 5 cycles on a write -> fb_we/fb_addr/fb_data held stable until accepted.
- is_empty=1 at frame_start -> zero writes, no dequeue, frame_done 3 cycles after frame_start. 20 queued sprites -> exactly 16 dequeue pulses.
- reset asserted during WRITE -> fb_we=0, busy=0 next cycle; no dequeue; next frame_start restarts normally.
